// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared encodings for the multicycle MIPS main controller and ALU decoder.
// Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       branch;
        logic       pcwrite;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_fsm_ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_output_decode
// Brief    : Moore decode of controller state into the datapath control word.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [CTRL_STATE_W-1:0] i_state,
    output ctrl_word_t              o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alusrcb = ALUSRCB_FOUR;
                o_ctrl.aluop   = ALUOP_ADD;
                o_ctrl.pcsrc   = PCSRC_ALU;
                o_ctrl.irwrite = 1'b1;
                o_ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                // branch target is formed here so BRANCH can compare A-B next
                o_ctrl.alusrcb = ALUSRCB_IMMSH;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.memtoreg   = 1'b1;
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.iord       = 1'b1;
                o_ctrl.memwrite   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_B;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.regdst     = 1'b1;
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alusrca    = 1'b1;
                o_ctrl.alusrcb    = ALUSRCB_B;
                o_ctrl.aluop      = ALUOP_SUB;
                o_ctrl.pcsrc      = PCSRC_ALUOUT;
                o_ctrl.branch     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pcsrc      = PCSRC_JUMP;
                o_ctrl.pcwrite    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Brief    : Multicycle MIPS main controller: state register and next-state logic.
// Revision : 1.0  initial release
// ============================================================================
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       Branch,
    output logic       PCWrite,
    output logic       Instr_Done,
    output logic       Illegal_Op
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    ctrl_word_t         w_ctrl;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW,
                    OP_SW:    w_next_state = S_MEMADR;
                    OP_RTYPE: w_next_state = S_EXECUTE;
                    OP_BEQ:   w_next_state = S_BRANCH;
                    OP_ADDI:  w_next_state = S_ADDIEX;
                    OP_J:     w_next_state = S_JUMP;
                    default:  w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: w_next_state = S_MEMWB;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            // completion states and unused encodings all return to FETCH
            default:   w_next_state = S_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign MemWrite   = w_ctrl.memwrite;
    assign IRWrite    = w_ctrl.irwrite;
    assign IorD       = w_ctrl.iord;
    assign RegDst     = w_ctrl.regdst;
    assign MemtoReg   = w_ctrl.memtoreg;
    assign RegWrite   = w_ctrl.regwrite;
    assign ALUSrcA    = w_ctrl.alusrca;
    assign ALUSrcB    = w_ctrl.alusrcb;
    assign PCSrc      = w_ctrl.pcsrc;
    assign ALUOp      = w_ctrl.aluop;
    assign Branch     = w_ctrl.branch;
    assign PCWrite    = w_ctrl.pcwrite;
    assign Instr_Done = w_ctrl.instr_done;
    assign Illegal_Op = (r_state == S_DECODE) && !is_supported_op(Opcode);

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_control_fsm
// Brief    : Directed self-checking bench comparing the control word per cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_main_control_fsm;

    // {MemWrite,IRWrite,IorD,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUOp,Branch,PCWrite,Instr_Done,Illegal_Op}
    localparam logic [16:0] C_FETCH    = 17'b0_1_0_0_0_0_0_01_00_00_0_1_0_0;
    localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_11_00_00_0_0_0_0;
    localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_11_00_00_0_0_0_1;
    localparam logic [16:0] C_MEMADR   = 17'b0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [16:0] C_MEMREAD  = 17'b0_0_1_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [16:0] C_MEMWB    = 17'b0_0_0_0_1_1_0_00_00_00_0_0_1_0;
    localparam logic [16:0] C_MEMWRITE = 17'b1_0_1_0_0_0_0_00_00_00_0_0_1_0;
    localparam logic [16:0] C_EXECUTE  = 17'b0_0_0_0_0_0_1_00_00_10_0_0_0_0;
    localparam logic [16:0] C_ALUWB    = 17'b0_0_0_1_0_1_0_00_00_00_0_0_1_0;
    localparam logic [16:0] C_BRANCH   = 17'b0_0_0_0_0_0_1_00_01_01_1_0_1_0;
    localparam logic [16:0] C_ADDIEX   = 17'b0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [16:0] C_ADDIWB   = 17'b0_0_0_0_0_1_0_00_00_00_0_0_1_0;
    localparam logic [16:0] C_JUMP     = 17'b0_0_0_0_0_0_0_00_10_00_0_1_1_0;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       w_memwrite, w_irwrite, w_iord, w_regdst, w_memtoreg, w_regwrite;
    logic       w_alusrca, w_branch, w_pcwrite, w_instr_done, w_illegal_op;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
    logic [16:0] w_word;

    int n_vec = 0;
    int n_err = 0;

    main_control_fsm #(.STATE_W(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .Opcode     (opcode),
        .MemWrite   (w_memwrite),
        .IRWrite    (w_irwrite),
        .IorD       (w_iord),
        .RegDst     (w_regdst),
        .MemtoReg   (w_memtoreg),
        .RegWrite   (w_regwrite),
        .ALUSrcA    (w_alusrca),
        .ALUSrcB    (w_alusrcb),
        .PCSrc      (w_pcsrc),
        .ALUOp      (w_aluop),
        .Branch     (w_branch),
        .PCWrite    (w_pcwrite),
        .Instr_Done (w_instr_done),
        .Illegal_Op (w_illegal_op)
    );

    assign w_word = {w_memwrite, w_irwrite, w_iord, w_regdst, w_memtoreg, w_regwrite,
                     w_alusrca, w_alusrcb, w_pcsrc, w_aluop, w_branch, w_pcwrite,
                     w_instr_done, w_illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // check the current cycle, then move to the next one
    task automatic cyc(input string tag, input logic [16:0] exp);
        check(tag, w_word, exp);
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b0;
        opcode = 6'b111111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // asynchronous reset raised between edges
        #2 rst = 1'b1;
        #1 check("reset_async", w_word, C_FETCH);
        @(negedge clk);
        check("reset_hold", w_word, C_FETCH);
        rst = 1'b0;

        opcode = 6'b100011;
        cyc("lw_fetch",   C_FETCH);
        cyc("lw_decode",  C_DECODE);
        cyc("lw_memadr",  C_MEMADR);
        cyc("lw_memread", C_MEMREAD);
        cyc("lw_memwb",   C_MEMWB);

        opcode = 6'b000000;
        cyc("r_fetch",   C_FETCH);
        cyc("r_decode",  C_DECODE);
        cyc("r_execute", C_EXECUTE);
        cyc("r_aluwb",   C_ALUWB);

        opcode = 6'b000100;
        cyc("beq_fetch",  C_FETCH);
        cyc("beq_decode", C_DECODE);
        cyc("beq_branch", C_BRANCH);

        opcode = 6'b101011;
        cyc("sw_fetch",    C_FETCH);
        cyc("sw_decode",   C_DECODE);
        cyc("sw_memadr",   C_MEMADR);
        cyc("sw_memwrite", C_MEMWRITE);

        opcode = 6'b111111;
        cyc("ill_fetch",  C_FETCH);
        cyc("ill_decode", C_DEC_ILL);

        opcode = 6'b001000;
        cyc("addi_fetch",  C_FETCH);
        cyc("addi_decode", C_DECODE);
        cyc("addi_ex",     C_ADDIEX);
        cyc("addi_wb",     C_ADDIWB);

        opcode = 6'b100011;
        cyc("lw2_fetch",  C_FETCH);
        cyc("lw2_decode", C_DECODE);
        cyc("lw2_memadr", C_MEMADR);
        check("lw2_memread", w_word, C_MEMREAD);
        #2 rst = 1'b1;
        #1 check("rst_midinstr", w_word, C_FETCH);
        @(negedge clk);
        check("rst_midinstr_hold", w_word, C_FETCH);
        rst = 1'b0;

        opcode = 6'b000010;
        cyc("j_fetch",  C_FETCH);
        cyc("j_decode", C_DECODE);
        cyc("j_jump",   C_JUMP);
        cyc("j_back",   C_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
